// File: rtl/gray_code_decoder.sv
// 3-bit reflected Gray to natural binary decoder with illegal-step detection.
// e/f/g are registered or combinational per REGISTER_OUT; out_valid/step_err always registered.
module gray_code_decoder #(
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic w,
  input  logic x,
  input  logic y,
  output logic e,
  output logic f,
  output logic g,
  output logic out_valid,
  output logic step_err
);

  localparam int unsigned CODE_W = 3;

  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] bin_c;
  logic [CODE_W-1:0] prev_code;
  logic [CODE_W-1:0] diff;
  logic              has_prev;
  logic              multi_bit;

  assign code  = {w, x, y};
  assign bin_c = {w, w ^ x, w ^ x ^ y};

  // More than one bit set among three: any pair both high.
  assign diff      = code ^ prev_code;
  assign multi_bit = (diff[0] & diff[1]) | (diff[0] & diff[2]) | (diff[1] & diff[2]);

  // Sample history and status flags; a reset drops any coincident sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_code <= '0;
      has_prev  <= 1'b0;
      out_valid <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      step_err  <= in_valid & has_prev & multi_bit;
      if (in_valid) begin
        prev_code <= code;
        has_prev  <= 1'b1;
      end
    end
  end

  generate
    if (REGISTER_OUT) begin : g_reg_out
      logic [CODE_W-1:0] bin_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          bin_q <= '0;
        end else if (in_valid) begin
          bin_q <= bin_c;
        end
      end

      assign {e, f, g} = bin_q;
    end else begin : g_comb_out
      assign {e, f, g} = bin_c;
    end
  endgenerate

endmodule

// File: tb/tb_gray_code_decoder.sv
// Self-checking bench for gray_code_decoder: vector table plus scoreboard, both output modes.
module tb_gray_code_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic w = 1'b0, x = 1'b0, y = 1'b0;
  logic e1, f1, g1, ov1, err1;
  logic e0, f0, g0, ov0, err0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_code_decoder #(.REGISTER_OUT(1'b1)) dut_reg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .w(w), .x(x), .y(y),
    .e(e1), .f(f1), .g(g1), .out_valid(ov1), .step_err(err1)
  );

  gray_code_decoder #(.REGISTER_OUT(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .w(w), .x(x), .y(y),
    .e(e0), .f(f0), .g(g0), .out_valid(ov0), .step_err(err0)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [2:0] code;
    logic [2:0] exp_efg;
    logic       exp_ov;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [2:0] efg;
    logic       err;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sbq[$];
  logic [2:0] gmap [8];
  logic [2:0] m_prev;
  logic       m_has_prev;

  function automatic vec_t mk(input logic r, input logic v, input logic [2:0] c,
                              input logic [2:0] efg, input logic ov, input logic er);
    vec_t t;
    t.r = r; t.v = v; t.code = c; t.exp_efg = efg; t.exp_ov = ov; t.exp_err = er;
    return t;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle, update the scoreboard model, then compare after the edge.
  task automatic apply(input int idx, input vec_t t);
    sb_t s;
    string tag;
    rst = t.r; in_valid = t.v; {w, x, y} = t.code;
    if (t.r) begin
      m_prev = 3'b000; m_has_prev = 1'b0; sbq.delete();
    end else if (t.v) begin
      s.efg = gmap[t.code];
      s.err = m_has_prev && ($countones(t.code ^ m_prev) > 1);
      sbq.push_back(s);
      m_prev = t.code; m_has_prev = 1'b1;
    end
    @(posedge clk);
    #1;
    tag = $sformatf("vec%0d", idx);
    check({tag, "_efg"}, {e1, f1, g1}, t.exp_efg);
    check({tag, "_out_valid"}, 3'(ov1), 3'(t.exp_ov));
    check({tag, "_step_err"}, 3'(err1), 3'(t.exp_err));
    check({tag, "_comb_out_valid"}, 3'(ov0), 3'(t.exp_ov));
    check({tag, "_comb_step_err"}, 3'(err0), 3'(t.exp_err));
    if (ov1) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s_sb: out_valid with empty scoreboard", tag);
      end else begin
        s = sbq.pop_front();
        check({tag, "_sb_efg"}, {e1, f1, g1}, s.efg);
        check({tag, "_sb_err"}, 3'(err1), 3'(s.err));
      end
    end
  endtask

  initial begin
    gmap[0] = 3'b000; gmap[1] = 3'b001; gmap[3] = 3'b010; gmap[2] = 3'b011;
    gmap[6] = 3'b100; gmap[7] = 3'b101; gmap[5] = 3'b110; gmap[4] = 3'b111;
    m_prev = 3'b000; m_has_prev = 1'b0;

    // reset
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 0, 0));
    // full Gray walk
    vecs.push_back(mk(0, 1, 3'b000, 3'b000, 1, 0));
    vecs.push_back(mk(0, 1, 3'b001, 3'b001, 1, 0));
    vecs.push_back(mk(0, 1, 3'b011, 3'b010, 1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 3'b011, 1, 0));
    vecs.push_back(mk(0, 1, 3'b110, 3'b100, 1, 0));
    vecs.push_back(mk(0, 1, 3'b111, 3'b101, 1, 0));
    vecs.push_back(mk(0, 1, 3'b101, 3'b110, 1, 0));
    vecs.push_back(mk(0, 1, 3'b100, 3'b111, 1, 0));
    // wrap 100->000 legal, then 000->011 illegal, 011->010 legal
    vecs.push_back(mk(0, 1, 3'b000, 3'b000, 1, 0));
    vecs.push_back(mk(0, 1, 3'b011, 3'b010, 1, 1));
    vecs.push_back(mk(0, 1, 3'b010, 3'b011, 1, 0));
    // accept 110 then hold with toggling inputs
    vecs.push_back(mk(0, 1, 3'b110, 3'b100, 1, 0));
    vecs.push_back(mk(0, 0, 3'b001, 3'b100, 0, 0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b100, 0, 0));
    vecs.push_back(mk(0, 0, 3'b010, 3'b100, 0, 0));
    // 110->101 illegal, mid-stream reset, 010 after reset never flags
    vecs.push_back(mk(0, 1, 3'b101, 3'b110, 1, 1));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 0, 0));
    vecs.push_back(mk(0, 1, 3'b010, 3'b011, 1, 0));
    // reset beats a coincident sample
    vecs.push_back(mk(1, 1, 3'b111, 3'b000, 0, 0));
    vecs.push_back(mk(0, 1, 3'b111, 3'b101, 1, 0));
    // repeat is legal, three-bit jump is not
    vecs.push_back(mk(0, 1, 3'b111, 3'b101, 1, 0));
    vecs.push_back(mk(0, 1, 3'b000, 3'b000, 1, 1));
    vecs.push_back(mk(0, 0, 3'b000, 3'b000, 0, 0));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Combinational mode: zero-latency decode of every code, in_valid ignored.
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cv;
      cv = 3'(c);
      {w, x, y} = cv;
      #1;
      check($sformatf("comb_code%0d_efg", c), {e0, f0, g0}, gmap[cv]);
    end
    @(posedge clk);
    #1;
    check("comb_idle_out_valid", 3'(ov0), 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
